load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sequencer between ALU/control and DataMemory. Executes LDUR/STUR-family accesses of 1/2/4/8 bytes.
//  DataMemory only moves 8 big-endian bytes per access, so sub-doubleword stores run read-modify-write.
//  Also does load extraction, zero/sign extension, and alignment/range faulting. Load result feeds the write-back mux.
// PARAMETERS
//  MEM_BYTES    1024  byte size of DataMemory; range limit for Address+7
//  CHECK_ALIGN  1     1: Address must be a multiple of access size, else fault
// PORTS
//  Clk           in   1   clock, all state updates on posedge
//  Reset         in   1   synchronous, active-high
//  Start         in   1   request strobe, sampled only in IDLE
//  IsStore       in   1   1 store, 0 load
//  Size          in   2   00 byte, 01 half, 10 word, 11 dword
//  SignExt       in   1   loads only: sign-extend result (LDURSW/LDURSH/LDURSB)
//  Address       in   64  byte address from ALU
//  StoreData     in   64  store operand; low Size bytes used
//  LoadData      out  64  extended load result, valid while Done=1, held until next load completes
//  Busy          out  1   state != IDLE
//  Done          out  1   1-cycle completion pulse
//  Fault         out  1   qualifies Done: access rejected, no memory side effect
//  MemAddress    out  64  to DataMemory Address (= latched request address)
//  MemWriteData  out  64  to DataMemory WriteData
//  MemoryRead    out  1   to DataMemory MemoryRead
//  MemoryWrite   out  1   to DataMemory MemoryWrite
//  MemReadData   in   64  from DataMemory ReadData, valid the cycle after MemoryRead
// BEHAVIOUR
//  Reset: state=IDLE; LoadData=0, Done=0, Fault=0, MemWriteData=0, request regs=0.
//  Reset: MemoryRead=MemoryWrite=0 combinationally while Reset=1, so no write in the reset cycle.
//  IDLE + Start: latch IsStore/Size/SignExt/Address/StoreData; check fault; Start while Busy is ignored.
//  Fault (combinational on latched inputs):
//    - Address+7 >= MEM_BYTES (all sizes), or
//    - CHECK_ALIGN && Address[Size-1:0] != 0
//    Faulting request -> DONE with Fault=1; MemoryRead/MemoryWrite never asserted.
//  States / moore outputs:
//    IDLE
//    RD         MemoryRead=1
//    RD_DATA    capture MemReadData
//    MERGE      build merged dword
//    WR         MemoryWrite=1
//    DONE       Done=1, then always -> IDLE
//  Load:         IDLE -> RD -> RD_DATA -> DONE.       Done 3 cycles after Start edge.
//  Store dword:  IDLE -> WR -> DONE.                  MemWriteData=StoreData; Done 2 cycles after Start.
//  Store <8B:    IDLE -> RD -> MERGE -> WR -> DONE.   Done 4 cycles after Start.
//  Big-endian: byte at Address is MemReadData[63:56].
//  Load extract, N=1/2/4/8 bytes:
//    field = MemReadData[63 -: 8N]
//    LoadData = SignExt ? sign-extend(field) : zero-extend(field)
//    SignExt ignored for dword.
//  Store merge: MemWriteData = {StoreData[8N-1:0], old[63-8N:0]}; old bytes written back unchanged.
//  Width rule: range check in 65-bit arithmetic, so Address near 2^64 cannot wrap past the check.
//  LoadData updates only on successful load DONE; stores and faults leave it unchanged.
//  Reset in any state: next edge -> IDLE, Done=0; an in-flight RMW is abandoned (no write if Reset in WR cycle).
//  MemAddress constant for the whole transaction.
// STRUCTURE
//  lsu_defs.vh: SIZE_B/H/W/D codes, state encodings, DATA_W=64.
//  Sub-module lsu_align (combinational):
//    - extract + sign/zero extend
//    - merge for stores
//    - fault check
//  FSM and registers stay in load_store_unit.
//  Bench instantiates load_store_unit + DataMemory with its initial image.
// TESTING
//  1 dword load @0x18 -> Done at +3 cycles, LoadData=0x0FFBEA7DEADBEEFF, Fault=0.
//  2 signed byte @0x19 -> 0xFFFFFFFFFFFFFFFB; unsigned word @0x1C -> 0x00000000EADBEEFF; signed word @0x1C -> 0xFFFFFFFFEADBEEFF.
//  3 store half 0xBEEF @0x08, then dword load @0x08:
//    - MemoryRead then MemoryWrite seen; Done at +4
//    - load returns 0xBEEF00000000000A
//  4 misaligned half @0x09, then dword @0x3FC -> each Done at +1 with Fault=1; MemoryRead/MemoryWrite stay 0; memory unchanged.
//  5 Reset during WR of a byte store @0x10 -> MemoryWrite=0 that cycle, IDLE next; dword @0x10 reads 0x5.
//  6 Start pulsed every cycle during a load -> only first accepted, one Done, Busy high through RD_DATA.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store sequencer: access size codes, FSM states, alignment helper.
package load_store_unit_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_D = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_MERGE   = 3'd3,
        ST_WR      = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(size_e s);
        case (s)
            SIZE_B:  align_mask = 3'b000;
            SIZE_H:  align_mask = 3'b001;
            SIZE_W:  align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request, response and DataMemory bus of the load/store unit; names are from the LSU's point of view.
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic              i_start;
    logic              i_is_store;
    logic [1:0]        i_size;
    logic              i_sign_ext;
    logic [DATA_W-1:0] i_address;
    logic [DATA_W-1:0] i_store_data;

    logic [DATA_W-1:0] o_load_data;
    logic              o_busy;
    logic              o_done;
    logic              o_fault;

    logic [DATA_W-1:0] o_mem_address;
    logic [DATA_W-1:0] o_mem_write_data;
    logic              o_mem_read;
    logic              o_mem_write;
    logic [DATA_W-1:0] i_mem_read_data;

    modport master (
        output i_start, i_is_store, i_size, i_sign_ext, i_address, i_store_data, i_mem_read_data,
        input  o_load_data, o_busy, o_done, o_fault,
        input  o_mem_address, o_mem_write_data, o_mem_read, o_mem_write
    );

    modport slave (
        input  i_start, i_is_store, i_size, i_sign_ext, i_address, i_store_data, i_mem_read_data,
        output o_load_data, o_busy, o_done, o_fault,
        output o_mem_address, o_mem_write_data, o_mem_read, o_mem_write
    );

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational datapath: big-endian load extraction/extension, store merge, and fault check.
module load_store_unit_align
    import load_store_unit_pkg::*;
#(
    parameter int MEM_BYTES   = 1024,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  size_e             i_size,
    input  logic              i_sign_ext,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [DATA_W-1:0] i_store_data,
    input  logic [DATA_W-1:0] i_chk_address,
    input  size_e             i_chk_size,
    output logic [DATA_W-1:0] o_load_val,
    output logic [DATA_W-1:0] o_merged,
    output logic              o_fault
);

    localparam logic [DATA_W:0] LP_LIMIT = (DATA_W+1)'(MEM_BYTES);

    // One extra bit so addresses near 2^64 cannot wrap below the limit.
    logic [DATA_W:0] w_end;
    logic            w_range_bad;
    logic            w_align_bad;
    logic            w_sx;

    assign w_end       = {1'b0, i_chk_address} + (DATA_W+1)'(7);
    assign w_range_bad = (w_end >= LP_LIMIT);
    assign w_align_bad = CHECK_ALIGN && ((i_chk_address[2:0] & align_mask(i_chk_size)) != 3'b000);
    assign o_fault     = w_range_bad || w_align_bad;
    assign w_sx        = i_sign_ext & i_mem_data[63];

    always_comb begin
        o_load_val = i_mem_data;
        o_merged   = i_store_data;
        case (i_size)
            SIZE_B: begin
                o_load_val = {{56{w_sx}}, i_mem_data[63:56]};
                o_merged   = {i_store_data[7:0], i_mem_data[55:0]};
            end
            SIZE_H: begin
                o_load_val = {{48{w_sx}}, i_mem_data[63:48]};
                o_merged   = {i_store_data[15:0], i_mem_data[47:0]};
            end
            SIZE_W: begin
                o_load_val = {{32{w_sx}}, i_mem_data[63:32]};
                o_merged   = {i_store_data[31:0], i_mem_data[31:0]};
            end
            default: begin
                o_load_val = i_mem_data;
                o_merged   = i_store_data;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer in front of DataMemory; sub-doubleword stores run read-modify-write.
// States: IDLE wait | RD MemoryRead | RD_DATA capture load | MERGE build dword | WR MemoryWrite | DONE pulse
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_BYTES   = 1024,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    load_store_unit_if.slave   bus
);

    state_e            r_state;
    logic              r_is_store;
    size_e             r_size;
    logic              r_sign_ext;
    logic [DATA_W-1:0] r_address;
    logic [DATA_W-1:0] r_store_data;
    logic [DATA_W-1:0] r_load_data;
    logic [DATA_W-1:0] r_wdata;
    logic              r_done;
    logic              r_fault;
    logic              r_mem_read;
    logic              r_mem_write;

    logic [DATA_W-1:0] w_load_val;
    logic [DATA_W-1:0] w_merged;
    logic              w_fault;

    load_store_unit_align #(
        .MEM_BYTES   (MEM_BYTES),
        .CHECK_ALIGN (CHECK_ALIGN)
    ) u_align (
        .i_size        (r_size),
        .i_sign_ext    (r_sign_ext),
        .i_mem_data    (bus.i_mem_read_data),
        .i_store_data  (r_store_data),
        .i_chk_address (bus.i_address),
        .i_chk_size    (size_e'(bus.i_size)),
        .o_load_val    (w_load_val),
        .o_merged      (w_merged),
        .o_fault       (w_fault)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_is_store   <= 1'b0;
            r_size       <= SIZE_B;
            r_sign_ext   <= 1'b0;
            r_address    <= '0;
            r_store_data <= '0;
            r_load_data  <= '0;
            r_wdata      <= '0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        r_is_store   <= bus.i_is_store;
                        r_size       <= size_e'(bus.i_size);
                        r_sign_ext   <= bus.i_sign_ext;
                        r_address    <= bus.i_address;
                        r_store_data <= bus.i_store_data;
                        r_fault      <= w_fault;
                        if (w_fault) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (bus.i_is_store && (size_e'(bus.i_size) == SIZE_D)) begin
                            r_wdata     <= bus.i_store_data;
                            r_mem_write <= 1'b1;
                            r_state     <= ST_WR;
                        end else begin
                            r_mem_read <= 1'b1;
                            r_state    <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    r_state <= r_is_store ? ST_MERGE : ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    r_load_data <= w_load_val;
                    r_done      <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_MERGE: begin
                    r_wdata     <= w_merged;
                    r_mem_write <= 1'b1;
                    r_state     <= ST_WR;
                end
                ST_WR: begin
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are gated by reset so an abandoned RMW never reaches memory.
    assign bus.o_mem_read       = r_mem_read & ~i_reset;
    assign bus.o_mem_write      = r_mem_write & ~i_reset;
    assign bus.o_mem_address    = r_address;
    assign bus.o_mem_write_data = r_wdata;
    assign bus.o_load_data      = r_load_data;
    assign bus.o_done           = r_done;
    assign bus.o_fault          = r_fault;
    assign bus.o_busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: byte-array DataMemory plus a byte-level reference model of every access.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int MEM_BYTES = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(
        .MEM_BYTES   (MEM_BYTES),
        .CHECK_ALIGN (1'b1)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic        fault;
        logic [63:0] ld;
        int          lat;
        int          rd;
        int          wr;
        longint      issue;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mem     [MEM_BYTES];
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [63:0] last_load;
    longint      cycle = 0;
    int          n_vec = 0;
    int          n_fail = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // DataMemory: 8 big-endian bytes per access, read data one cycle after MemoryRead.
    always @(posedge clk) begin
        if (bus.o_mem_write && bus.o_mem_address < 64'(MEM_BYTES - 7)) begin
            for (int i = 0; i < 8; i++)
                mem[int'(bus.o_mem_address[31:0]) + i] <= bus.o_mem_write_data[63 - 8*i -: 8];
        end
        if (bus.o_mem_read && bus.o_mem_address < 64'(MEM_BYTES - 7)) begin
            for (int i = 0; i < 8; i++)
                bus.i_mem_read_data[63 - 8*i -: 8] <= mem[int'(bus.o_mem_address[31:0]) + i];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic ref_fault(input logic [63:0] a, input int n);
        logic [64:0] e;
        e = {1'b0, a} + 65'd7;
        return (e >= 65'(MEM_BYTES)) || ((a % 64'(n)) != 64'd0);
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] a, input int n, input logic sx);
        logic [63:0] v;
        int base;
        v = 64'd0;
        base = int'(a[31:0]);
        for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_mem[base + i]);
        if (sx && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        return v;
    endfunction

    task automatic push_exp(input logic st, input logic [1:0] sz, input logic sx, input logic [63:0] a,
                            input logic [63:0] d, input bit use_exp, input logic [63:0] exp_v);
        exp_t e;
        int n;
        int base;
        n = 1 << sz;
        e.fault = ref_fault(a, n);
        e.issue = cycle;
        if (e.fault) begin
            e.lat = 1; e.rd = 0; e.wr = 0;
        end else if (st) begin
            e.lat = (n == 8) ? 2 : 4;
            e.rd  = (n == 8) ? 0 : 1;
            e.wr  = 1;
            base = int'(a[31:0]);
            for (int i = 0; i < n; i++) ref_mem[base + i] = 8'((d >> (8*(n-1-i))) & 64'hFF);
        end else begin
            e.lat = 3; e.rd = 1; e.wr = 0;
            last_load = use_exp ? exp_v : ref_load(a, n, sx);
        end
        e.ld = last_load;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.o_busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (bus.o_busy) chk("idle_timeout", 64'(bus.o_busy), 64'd0);
    endtask

    task automatic drive(input logic st, input logic [1:0] sz, input logic sx,
                         input logic [63:0] a, input logic [63:0] d);
        bus.i_start      = 1'b1;
        bus.i_is_store   = st;
        bus.i_size       = sz;
        bus.i_sign_ext   = sx;
        bus.i_address    = a;
        bus.i_store_data = d;
    endtask

    task automatic issue(input logic st, input logic [1:0] sz, input logic sx, input logic [63:0] a,
                         input logic [63:0] d, input bit use_exp, input logic [63:0] exp_v);
        wait_idle();
        push_exp(st, sz, sx, a, d, use_exp, exp_v);
        drive(st, sz, sx, a, d);
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    // Monitor: counts memory strobes per transaction and scores every Done.
    always @(negedge clk) begin
        if (rst) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (bus.o_mem_read)  rd_cnt++;
            if (bus.o_mem_write) wr_cnt++;
            if (bus.o_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("fault", 64'(bus.o_fault), 64'(e.fault));
                    chk("latency", 64'(cycle - e.issue), 64'(e.lat));
                    chk("mem_reads", 64'(rd_cnt), 64'(e.rd));
                    chk("mem_writes", 64'(wr_cnt), 64'(e.wr));
                    chk("load_data", bus.o_load_data, e.ld);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    initial begin
        logic [1:0]  sz;
        logic [63:0] a;
        int          n;
        int          r;
        int          k;
        int          bad;

        rst = 1'b1;
        last_load = 64'd0;
        drive(1'b0, 2'b00, 1'b0, 64'd0, 64'd0);
        bus.i_start = 1'b0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            ref_mem[i] = (i < 32) ? 8'h00 : 8'($urandom_range(0, 255));
        end
        ref_mem[7]  = 8'h01;
        ref_mem[15] = 8'h0A;
        ref_mem[23] = 8'h05;
        for (int i = 0; i < 8; i++) ref_mem[24 + i] = 8'((64'h0FFB_EA7D_EADB_EEFF >> (56 - 8*i)) & 64'hFF);
        for (int i = 0; i < MEM_BYTES; i++) mem[i] <= ref_mem[i];

        repeat (3) @(negedge clk);
        chk("rst_mem_read", 64'(bus.o_mem_read), 64'd0);
        chk("rst_mem_write", 64'(bus.o_mem_write), 64'd0);
        chk("rst_done", 64'(bus.o_done), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_fault", 64'(bus.o_fault), 64'd0);
        chk("rst_load_data", bus.o_load_data, 64'd0);
        chk("rst_wdata", bus.o_mem_write_data, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(1'b0, SIZE_D, 1'b0, 64'h18, 64'd0, 1'b1, 64'h0FFB_EA7D_EADB_EEFF);
        issue(1'b0, SIZE_B, 1'b1, 64'h19, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB);
        issue(1'b0, SIZE_W, 1'b0, 64'h1C, 64'd0, 1'b1, 64'h0000_0000_EADB_EEFF);
        issue(1'b0, SIZE_W, 1'b1, 64'h1C, 64'd0, 1'b1, 64'hFFFF_FFFF_EADB_EEFF);
        issue(1'b1, SIZE_H, 1'b0, 64'h08, 64'h1234_5678_9ABC_BEEF, 1'b0, 64'd0);
        issue(1'b0, SIZE_D, 1'b0, 64'h08, 64'd0, 1'b1, 64'hBEEF_0000_0000_000A);
        issue(1'b1, SIZE_H, 1'b0, 64'h09, 64'hFFFF, 1'b0, 64'd0);
        issue(1'b0, SIZE_D, 1'b0, 64'h3FC, 64'd0, 1'b0, 64'd0);
        issue(1'b1, SIZE_D, 1'b0, 64'h3F8, 64'hCAFE_F00D_1234_5678, 1'b0, 64'd0);
        issue(1'b0, SIZE_D, 1'b0, 64'h3F8, 64'd0, 1'b0, 64'd0);
        issue(1'b0, SIZE_W, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b0, 64'd0);

        // Reset lands on the WR cycle of a byte RMW: nothing may be written.
        wait_idle();
        drive(1'b1, SIZE_B, 1'b0, 64'h10, 64'h77);
        @(negedge clk);
        bus.i_start = 1'b0;
        k = 0;
        while (!bus.o_mem_write && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("rmw_reached_wr", 64'(bus.o_mem_write), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_gates_write", 64'(bus.o_mem_write), 64'd0);
        @(negedge clk);
        chk("rst_idle_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_idle_done", 64'(bus.o_done), 64'd0);
        chk("rst_clears_load", bus.o_load_data, 64'd0);
        last_load = 64'd0;
        rst = 1'b0;
        @(negedge clk);
        issue(1'b0, SIZE_D, 1'b0, 64'h10, 64'd0, 1'b1, 64'h0000_0000_0000_0005);

        // Start held high with changing fields through a whole load.
        wait_idle();
        push_exp(1'b0, SIZE_D, 1'b0, 64'h18, 64'd0, 1'b1, 64'h0FFB_EA7D_EADB_EEFF);
        drive(1'b0, SIZE_D, 1'b0, 64'h18, 64'd0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (!bus.o_done) chk("busy_held", 64'(bus.o_busy), 64'd1);
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1,
                  64'($urandom_range(0, 255)) << 3, {$urandom, $urandom});
        end while (!bus.o_done && k < 10);
        bus.i_start = 1'b0;
        if (!bus.o_done) chk("spam_done_timeout", 64'd0, 64'd1);
        repeat (3) @(negedge clk);

        for (int t = 0; t < 300; t++) begin
            sz = 2'($urandom_range(0, 3));
            n  = 1 << sz;
            r  = $urandom_range(0, 9);
            if (r < 7)       a = 64'($urandom_range(0, MEM_BYTES - 8)) & ~64'(n - 1);
            else if (r == 7) a = 64'($urandom_range(0, MEM_BYTES - 8)) | 64'd1;
            else if (r == 8) a = 64'(MEM_BYTES - $urandom_range(1, 16));
            else             a = {32'hFFFF_FFFF, $urandom} & ~64'(n - 1);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                  {$urandom, $urandom}, 1'b0, 64'd0);
        end

        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("pending_done", 64'(sb.size()), 64'd0);
        bad = 0;
        for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_image", 64'(bad), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
